// File: rtl/sparc_mem_responder.sv
// Big-endian byte memory responder for the SPARC datapath, with a four-phase MFC handshake and a programmable wait latency.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses are rejected with Mem_Error instead of being force-aligned.
module sparc_mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              RAM_enable,
   input  logic [5:0]        RAM_OpCode,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic              MFC,
   output logic              Mem_Error
);

   localparam int DEPTH = 2**ADDR_W;

   localparam logic [5:0] OP_LD   = 6'b000000;
   localparam logic [5:0] OP_LDUB = 6'b000001;
   localparam logic [5:0] OP_LDUH = 6'b000010;
   localparam logic [5:0] OP_LDSB = 6'b001001;
   localparam logic [5:0] OP_LDSH = 6'b001010;
   localparam logic [5:0] OP_ST   = 6'b000100;
   localparam logic [5:0] OP_STB  = 6'b000101;
   localparam logic [5:0] OP_STH  = 6'b000110;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   logic [7:0] Mem [0:DEPTH-1];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [5:0]        op_q, op_d;
   logic [31:0]       din_q, din_d;
   logic [31:0]       dout_q, dout_d;
   logic              mfc_q, mfc_d;
   logic              err_q, err_d;

   logic              is_load, is_store, is_half, is_word, is_signed, is_byte;
   logic              acc_err;
   logic [ADDR_W-1:0] base_addr;
   logic [7:0]        rd_byte [0:3];
   logic [31:0]       load_data;
   logic [31:0]       store_shift;
   logic [3:0]        byte_mask;
   logic              mem_we;
   logic [3:0]        wr_en;

   // Access decode works only on the captured request, never on live inputs
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_word   = 1'b0;
      is_signed = 1'b0;
      case (op_q)
         OP_LD:   begin is_load  = 1'b1; is_word = 1'b1; end
         OP_LDUB: begin is_load  = 1'b1; is_byte = 1'b1; end
         OP_LDUH: begin is_load  = 1'b1; is_half = 1'b1; end
         OP_LDSB: begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         OP_LDSH: begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         OP_ST:   begin is_store = 1'b1; is_word = 1'b1; end
         OP_STB:  begin is_store = 1'b1; is_byte = 1'b1; end
         OP_STH:  begin is_store = 1'b1; is_half = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      acc_err = !(is_load || is_store);
`ifdef MEM_ALIGN_CHECK_EN
      if (is_half && addr_q[0])
         acc_err = 1'b1;
      if (is_word && (addr_q[1:0] != 2'b00))
         acc_err = 1'b1;
`endif
      base_addr = addr_q;
      if (is_half)
         base_addr[0] = 1'b0;
      if (is_word)
         base_addr[1:0] = 2'b00;
   end

   always_comb begin
      for (int k = 0; k < 4; k++)
         rd_byte[k] = Mem[base_addr + ADDR_W'(k)];
      load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      if (is_byte)
         load_data = {{24{is_signed & rd_byte[0][7]}}, rd_byte[0]};
      else if (is_half)
         load_data = {{16{is_signed & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
   end

   // Store data is left-justified so byte k of the access is always bits [31-8k -: 8]
   always_comb begin
      store_shift = din_q;
      byte_mask   = 4'b1111;
      if (is_byte) begin
         store_shift = {din_q[7:0], 24'h0};
         byte_mask   = 4'b0001;
      end else if (is_half) begin
         store_shift = {din_q[15:0], 16'h0};
         byte_mask   = 4'b0011;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      din_d   = din_q;
      dout_d  = dout_q;
      mfc_d   = mfc_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (RAM_enable) begin
               addr_d  = Address;
               op_d    = RAM_OpCode;
               din_d   = DataIn;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               mfc_d   = 1'b1;
               err_d   = acc_err;
               mem_we  = is_store && !acc_err;
               if (is_load && !acc_err)
                  dout_d = load_data;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!RAM_enable) begin
               mfc_d   = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         op_q    <= 6'd0;
         din_q   <= 32'd0;
         dout_q  <= 32'd0;
         mfc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         mfc_q   <= mfc_d;
         err_q   <= err_d;
      end
   end

   // mem_we is derived from state_q, so an asynchronous reset in WAIT cancels the write
   assign wr_en = mem_we ? byte_mask : 4'b0000;

   always_ff @(posedge Clk) begin
      for (int k = 0; k < 4; k++)
         if (wr_en[k])
            Mem[base_addr + ADDR_W'(k)] <= store_shift[31-8*k -: 8];
   end

   assign DataOut   = dout_q;
   assign MFC       = mfc_q;
   assign Mem_Error = err_q;

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Directed bench for sparc_mem_responder: stores, loads, handshake timing, errors and reset mid-access.
module tb_sparc_mem_responder;

   localparam int ADDR_W = 9;
   localparam int WAITC  = 2;

   logic              clk = 1'b0;
   logic              clr_n = 1'b0;
   logic              ram_enable = 1'b0;
   logic [5:0]        ram_opcode = 6'd0;
   logic [ADDR_W-1:0] address = '0;
   logic [31:0]       data_in = 32'd0;
   logic [31:0]       data_out;
   logic              mfc;
   logic              mem_error;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_w8;

   sparc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
      .Clk        (clk),
      .Clr        (clr_n),
      .RAM_enable (ram_enable),
      .RAM_OpCode (ram_opcode),
      .Address    (address),
      .DataIn     (data_in),
      .DataOut    (data_out),
      .MFC        (mfc),
      .Mem_Error  (mem_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-14s got=%08h", tag, got);
      end else begin
         $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input int a);
      return {dut.Mem[a], dut.Mem[a+1], dut.Mem[a+2], dut.Mem[a+3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise a request and wait for MFC; leaves RAM_enable high in DONE
   task automatic run_req(input string tag, input logic [5:0] op, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d);
      int edges = 0;
      ram_opcode = op;
      address    = a;
      data_in    = d;
      ram_enable = 1'b1;
      while (edges < 50) begin
         tick();
         edges++;
         if (mfc) break;
      end
      check({tag, "_lat"}, 32'(edges), 32'(WAITC + 2));
   endtask

   task automatic release_req(input string tag);
      ram_enable = 1'b0;
      tick();
      check({tag, "_mfc0"}, {31'd0, mfc}, 32'd0);
   endtask

   initial begin
      int edges;
      for (int i = 8; i < 12; i++) dut.Mem[i] = 8'hFF;
      dut.Mem[20]  = 8'h5A;
      dut.Mem[511] = 8'hC3;
      tick();
      tick();
      check("rst_mfc", {31'd0, mfc}, 32'd0);
      check("rst_dout", data_out, 32'd0);
      check("rst_err", {31'd0, mem_error}, 32'd0);
      check("rst_state", 32'(dut.state_q), 32'd0);
      clr_n = 1'b1;
      tick();

      run_req("st8", 6'b000100, 9'd8, 32'h12345678);
      check("st8_err", {31'd0, mem_error}, 32'd0);
      check("st8_dout", data_out, 32'd0);
      release_req("st8");
      check("st8_mem", mem_word(8), 32'h12345678);

      // Re-raise right after release: accepted from IDLE
      run_req("ld8", 6'b000000, 9'd8, 32'h0);
      check("ld8_dout", data_out, 32'h12345678);
      check("ld8_err", {31'd0, mem_error}, 32'd0);
      release_req("ld8");

      dut.Mem[8] = 8'h80;
      dut.Mem[9] = 8'h01;
      run_req("ldsb", 6'b001001, 9'd8, 32'h0);
      check("ldsb_dout", data_out, 32'hFFFFFF80);
      release_req("ldsb");
      run_req("ldub", 6'b000001, 9'd8, 32'h0);
      check("ldub_dout", data_out, 32'h00000080);
      release_req("ldub");
      run_req("ldsh", 6'b001010, 9'd8, 32'h0);
      check("ldsh_dout", data_out, 32'hFFFF8001);
      release_req("ldsh");
      run_req("lduh", 6'b000010, 9'd8, 32'h0);
      check("lduh_dout", data_out, 32'h00008001);
      release_req("lduh");
      run_req("ldub511", 6'b000001, 9'h1FF, 32'h0);
      check("ldub511_dout", data_out, 32'h000000C3);
      release_req("ldub511");

      // Hold: MFC stays high, input changes during DONE ignored
      run_req("hold", 6'b000000, 9'd8, 32'h0);
      for (int i = 0; i < 5; i++) begin
         address    = 9'd20;
         ram_opcode = 6'b000001;
         tick();
         check("hold_mfc", {31'd0, mfc}, 32'd1);
      end
      check("hold_dout", data_out, 32'h80015678);
      release_req("hold");
      check("hold_state", 32'(dut.state_q), 32'd0);

      // Drop RAM_enable during WAIT: access completes with a single-cycle MFC pulse
      ram_opcode = 6'b000010;
      address    = 9'd10;
      ram_enable = 1'b1;
      tick();
      ram_enable = 1'b0;
      edges = 0;
      while (edges < 50) begin
         tick();
         edges++;
         if (mfc) break;
      end
      check("drop_lat", 32'(edges), 32'(WAITC + 1));
      check("drop_dout", data_out, 32'h00005678);
      tick();
      check("drop_mfc0", {31'd0, mfc}, 32'd0);
      check("drop_state", 32'(dut.state_q), 32'd0);

      run_req("stmis", 6'b000100, 9'd9, 32'hAABBCCDD);
`ifdef MEM_ALIGN_CHECK_EN
      check("stmis_err", {31'd0, mem_error}, 32'd1);
      exp_w8 = 32'h80015678;
`else
      check("stmis_err", {31'd0, mem_error}, 32'd0);
      exp_w8 = 32'hAABBCCDD;
`endif
      release_req("stmis");
      check("stmis_mem", mem_word(8), exp_w8);

      run_req("badop", 6'b111111, 9'd8, 32'h01020304);
      check("badop_err", {31'd0, mem_error}, 32'd1);
      check("badop_dout", data_out, 32'h00005678);
      release_req("badop");
      check("badop_mem", mem_word(8), exp_w8);
      check("badop_err0", {31'd0, mem_error}, 32'd0);

      // Reset during WAIT of STB to 20: write must be cancelled
      ram_opcode = 6'b000101;
      address    = 9'd20;
      data_in    = 32'h00000011;
      ram_enable = 1'b1;
      tick();
      tick();
      clr_n = 1'b0;
      #1;
      check("rstw_mfc", {31'd0, mfc}, 32'd0);
      check("rstw_state", 32'(dut.state_q), 32'd0);
      ram_enable = 1'b0;
      tick();
      tick();
      clr_n = 1'b1;
      tick();
      check("rstw_mem", {24'd0, dut.Mem[20]}, 32'h0000005A);
      check("rstw_mfc2", {31'd0, mfc}, 32'd0);

      run_req("stb20", 6'b000101, 9'd20, 32'hDEADBE11);
      release_req("stb20");
      check("stb20_mem", {dut.Mem[19], dut.Mem[20], dut.Mem[21], 8'h00},
            {dut.Mem[19], 8'h11, dut.Mem[21], 8'h00});
      check("stb20_byte", {24'd0, dut.Mem[20]}, 32'h00000011);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

●

// File: doc/sparc_mem_responder.md
Name: sparc_mem_responder

Overview:
- Byte-addressed, big-endian memory responder on the datapath memory port.
- Serves load/store requests from the control unit (RAM_enable, RAM_OpCode, address from MAR, store data from MDR).
- Returns load data to the MDR input mux and signals completion with MFC.
- Four-phase handshake with programmable access latency, so the control unit's MFC wait states are actually exercised.

Parameters:
- ADDR_W, 9, byte-address width; memory depth is 2**ADDR_W bytes.
- WAIT_CYCLES, 2, extra cycles between request capture and MFC assertion (0..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Clr  in  1  asynchronous, active-low reset.
- RAM_enable  in  1  request strobe from the control unit; held high until MFC is seen.
- RAM_OpCode  in  6  SPARC op3 of the access.
- Address  in  ADDR_W  byte address, from MAR.
- DataIn  in  32  store data, from MDR; low byte/halfword used for STB/STH.
- DataOut  out  32  load result, extended to 32 bits.
- MFC  out  1  memory function complete.
- Mem_Error  out  1  valid with MFC: misaligned access or unsupported opcode.

Behaviour:
- Reset (Clr low, async): MFC=0, DataOut=0, Mem_Error=0, FSM=IDLE, wait counter=0. Memory array is not cleared; benches preload Mem[] hierarchically.
- Storage: reg [7:0] Mem[0:2**ADDR_W-1]. Big-endian: word at A is Mem[A] (MSB) through Mem[A+3] (LSB).
- Supported opcodes:
  - 000000 LD, 000001 LDUB, 000010 LDUH, 001001 LDSB, 001010 LDSH.
  - 000100 ST, 000101 STB, 000110 STH.
  - Any other opcode: no memory access, Mem_Error=1.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: at the edge where RAM_enable=1, latch Address, RAM_OpCode and DataIn; cnt<=WAIT_CYCLES; go to WAIT.
  - WAIT: if cnt!=0, decrement. If cnt==0:
    - perform the access: store writes bytes; load drives DataOut (zero-extend LDUB/LDUH, sign-extend LDSB/LDSH);
    - set MFC=1 and Mem_Error;
    - go to DONE.
  - DONE: hold MFC, DataOut and Mem_Error while RAM_enable=1. At the edge where RAM_enable=0: MFC<=0, Mem_Error<=0, go to IDLE. DataOut keeps its last load value.
- Latency: request sampled at edge N gives MFC high after edge N+1+WAIT_CYCLES. With WAIT_CYCLES=0, MFC is high after edge N+1.
- Inputs are captured once per request; changes to Address, DataIn or OpCode during WAIT or DONE are ignored.
- Stores leave DataOut unchanged.
- If RAM_enable drops during WAIT, the access still completes. MFC pulses for 1 cycle, then the FSM returns to IDLE.
- Back-to-back requests: a new request is accepted only from IDLE, so there is at least 1 idle cycle with MFC=0 between transactions.
- Address arithmetic wraps modulo 2**ADDR_W.
- Reset mid-transaction: the write is committed only on the WAIT→DONE edge. A reset before that edge leaves memory unchanged; a reset after it keeps the write.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword access with Address[0]=1, or word access with Address[1:0]!=0, performs no memory access.
  - Mem_Error=1 is returned with MFC; DataOut is unchanged.
- Undefined:
  - Alignment is forced: halfword uses Address&~1, word uses Address&~3.
  - Mem_Error is raised only for unsupported opcodes.

Test Plan:
- Word store then load:
  - Mem[8..11]=FF; ST DataIn=32'h12345678 at addr 8.
  - Result: MFC rises 3 edges after the request edge (WAIT_CYCLES=2); Mem[8..11]=12,34,56,78.
  - LD at addr 8 returns DataOut=32'h12345678, Mem_Error=0.
- Sub-word loads:
  - Mem[8]=8'h80, Mem[9]=8'h01.
  - LDSB 8 → 32'hFFFFFF80; LDUB 8 → 32'h00000080; LDSH 8 → 32'hFFFF8001; LDUH 8 → 32'h00008001.
- Handshake hold:
  - Keep RAM_enable high 5 cycles after MFC: MFC stays 1 throughout.
  - Drop RAM_enable: MFC=0 after the next edge.
  - Re-raise RAM_enable the next cycle: the new request is accepted.
- Misalignment, MEM_ALIGN_CHECK_EN defined: ST at addr 9 → MFC=1, Mem_Error=1, Mem[8..11] unchanged.
- Misalignment, MEM_ALIGN_CHECK_EN undefined: ST at addr 9 writes Mem[8..11].
- Unsupported opcode and reset:
  - OpCode 6'b111111 → MFC with Mem_Error=1, no memory change.
  - Clr pulsed low during WAIT of an STB to addr 20 → Mem[20] unchanged, MFC=0, FSM in IDLE.
